argmax_sequencer: RTL and testbench
===================================

ARGMAX_SEQUENCER -- requirements
Module: argmax_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, bit width of one fully-connected output score.
REQ-002 SHALL have parameter IDX_SIZE, default 4, bit width of a class index.
REQ-003 SHALL have parameter NUM_CLASSES, default 10, number of scores per frame; legal range 2 to 2^IDX_SIZE.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle request to begin a new frame.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning in_data holds a valid score.
REQ-008 SHALL have port in_data, input, WORD_SIZE bits, an unsigned score from the FC layer, in class order 0 to NUM_CLASSES-1.
REQ-009 SHALL have port in_ready, output, 1 bit, meaning the block accepts a score this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the result is available.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-012 SHALL have port out_class, output, IDX_SIZE bits, the index of the maximum score.
REQ-013 SHALL have port out_value, output, WORD_SIZE bits, the maximum score.
REQ-014 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, COLLECT and RESULT.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 moves the FSM to COLLECT on the next edge, clears the beat counter to 0 and clears max_val/max_idx to 0.
REQ-017 COLLECT: in_ready=1 combinationally; a beat is accepted on a cycle where in_valid and in_ready are both 1.
REQ-018 Each accepted beat SHALL take index equal to the beat counter value, and the counter SHALL increment by 1.
REQ-019 The first beat of a frame (counter=0) SHALL load max_val=in_data and max_idx=0 unconditionally.
REQ-020 For each later beat, if max_val > in_data (unsigned) the stored max is kept; otherwise max_val=in_data and max_idx=counter.
REQ-021 Ties SHALL therefore resolve to the later index, matching the pairwise comparator in the same FC path.
REQ-022 Cycles with in_valid=0 in COLLECT SHALL leave all state unchanged, with no timeout.
REQ-023 When beat NUM_CLASSES-1 is accepted, the FSM SHALL enter RESULT on the same edge; out_valid rises in the cycle after the last beat is accepted (1-cycle latency).
REQ-024 RESULT: out_valid=1 and in_ready=0; out_class=max_idx and out_value=max_val, both registered and stable while out_valid=1.
REQ-025 RESULT: out_valid=1 together with out_ready=1 SHALL return the FSM to IDLE on the next edge; out_valid SHALL stay high until that happens.
REQ-026 start SHALL be ignored in COLLECT and RESULT; start in the same cycle as the RESULT handshake SHALL also be ignored (the FSM returns to IDLE).
REQ-027 The beat counter SHALL be IDX_SIZE bits wide and SHALL never exceed NUM_CLASSES-1, so it does not wrap within a frame.
REQ-028 out_class and out_value SHALL hold their last values in IDLE until the next frame overwrites them.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state=IDLE, counter=0, max_val=0, max_idx=0, out_valid=0, in_ready=0, busy=0, out_class=0 and out_value=0.
REQ-030 Reset SHALL take priority over every other input, including reset asserted mid-COLLECT or mid-RESULT; the partial frame is discarded and no result is produced.
REQ-031 There SHALL be no asynchronous behaviour; rst_n is sampled only on the clk edge.

Verification
REQ-032 Basic frame: start, then 10 back-to-back beats {3,7,2,9,1,0,4,9-1=8,5,6} -> out_valid 1 cycle after the 10th beat with out_class=3 and out_value=9; out_ready=1 returns the FSM to IDLE.
REQ-033 Tie and bubbles: beats {5,5,5,5,5,5,5,5,5,5} with in_valid low on random cycles -> out_class=9 and out_value=5; state is unchanged during bubbles.
REQ-034 Backpressure: in RESULT, hold out_ready=0 for 20 cycles with start pulsed -> out_valid stays 1, outputs are stable, start is ignored; the FSM reaches IDLE only after out_ready=1.
REQ-035 Extremes: first beat 16'hFFFF and the others 0 -> out_class=0 and out_value=16'hFFFF; all beats 0 -> out_class=9 and out_value=0.
REQ-036 Reset mid-frame: rst_n=0 after beat 4 -> all outputs 0 and state IDLE; a new start followed by a full frame produces the correct result with no residue from the discarded frame.
REQ-037 Parameter sweep: NUM_CLASSES=16 with IDX_SIZE=4 and maximum at index 15 -> out_class=15, with no counter wrap.

Source files
------------

// File: rtl/argmax_sequencer.sv
// Streaming argmax over one frame of NUM_CLASSES unsigned scores from the FC layer.
// Reports the index and value of the largest score; ties resolve to the later index.
module argmax_sequencer #(
    parameter int WORD_SIZE   = 16,
    parameter int IDX_SIZE    = 4,
    parameter int NUM_CLASSES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_SIZE-1:0]  out_class,
    output logic [WORD_SIZE-1:0] out_value,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RESULT
    } state_t;

    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(NUM_CLASSES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [IDX_SIZE-1:0]  r_cnt;
    logic [WORD_SIZE-1:0] r_max_val;
    logic [IDX_SIZE-1:0]  r_max_idx;
    logic [WORD_SIZE-1:0] r_out_value;
    logic [IDX_SIZE-1:0]  r_out_class;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_take;
    logic [WORD_SIZE-1:0] w_new_val;
    logic [IDX_SIZE-1:0]  w_new_idx;

    assign w_accept  = (r_state == COLLECT) && in_valid;
    assign w_last    = w_accept && (r_cnt == LAST_IDX);
    // Replace on >= so equal scores move the winner to the later class.
    assign w_take    = (r_cnt == '0) || !(r_max_val > in_data);
    assign w_new_val = w_take ? in_data : r_max_val;
    assign w_new_idx = w_take ? r_cnt : r_max_idx;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (w_last) w_next = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_max_val   <= '0;
            r_max_idx   <= '0;
            r_out_value <= '0;
            r_out_class <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_cnt     <= '0;
                r_max_val <= '0;
                r_max_idx <= '0;
            end
            if (w_accept) begin
                r_max_val <= w_new_val;
                r_max_idx <= w_new_idx;
                // Counter parks on the last index so it never wraps.
                if (!w_last) r_cnt <= r_cnt + 1'b1;
            end
            // Result registers are loaded with the final max and held until the next frame ends.
            if (w_last) begin
                r_out_value <= w_new_val;
                r_out_class <= w_new_idx;
            end
        end
    end

    assign out_class = r_out_class;
    assign out_value = r_out_value;

endmodule

// File: tb/tb_argmax_sequencer.sv
// Directed bench for argmax_sequencer: default 10-class instance plus a 16-class instance.
module tb_argmax_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, busy;
    logic [3:0]  out_class;
    logic [15:0] out_value;

    logic        start16, in_valid16, out_ready16;
    logic [15:0] in_data16;
    logic        in_ready16, out_valid16, busy16;
    logic [3:0]  out_class16;
    logic [15:0] out_value16;

    int checks   = 0;
    int failures = 0;
    logic [15:0] beats [16];

    always #5 clk = ~clk;

    argmax_sequencer #(.WORD_SIZE(16), .IDX_SIZE(4), .NUM_CLASSES(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_value(out_value), .busy(busy)
    );

    argmax_sequencer #(.WORD_SIZE(16), .IDX_SIZE(4), .NUM_CLASSES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .in_valid(in_valid16), .in_data(in_data16),
        .in_ready(in_ready16), .out_valid(out_valid16), .out_ready(out_ready16),
        .out_class(out_class16), .out_value(out_value16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives beats[0..n-1]; optional random bubble cycles in between.
    task automatic send_beats(input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'(($urandom_range(0, 65535)));
                @(negedge clk);
                check("bubble_state", {in_ready, busy, out_valid}, 3'b110);
            end
            if (i == n - 1) check("pre_last_valid", out_valid, 0);
            in_valid = 1'b1;
            in_data  = beats[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 16'h0;
    endtask

    task automatic check_result(input string tag, input logic [3:0] cls, input logic [15:0] val);
        check({tag, "_valid"}, {out_valid, in_ready, busy}, 3'b101);
        check({tag, "_class"}, out_class, cls);
        check({tag, "_value"}, out_value, val);
    endtask

    task automatic handshake_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        start16 = 1'b0; in_valid16 = 1'b0; in_data16 = 16'h0; out_ready16 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {out_valid, in_ready, busy}, 3'b000);
        check("reset_class", out_class, 0);
        check("reset_value", out_value, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {out_valid, in_ready, busy}, 3'b000);

        // Basic frame
        beats[0] = 3; beats[1] = 7; beats[2] = 2; beats[3] = 9; beats[4] = 1;
        beats[5] = 0; beats[6] = 4; beats[7] = 8; beats[8] = 5; beats[9] = 6;
        pulse_start();
        check("collect_entry", {out_valid, in_ready, busy}, 3'b011);
        send_beats(10, 1'b0);
        check_result("basic", 4'd3, 16'd9);
        handshake_out();
        check("basic_idle", {out_valid, in_ready, busy}, 3'b000);
        check("basic_hold_class", out_class, 3);
        check("basic_hold_value", out_value, 9);

        // Ties with bubbles
        for (int i = 0; i < 10; i++) beats[i] = 16'd5;
        pulse_start();
        send_beats(10, 1'b1);
        check_result("tie", 4'd9, 16'd5);

        // Backpressure with start pulses ignored
        for (int k = 0; k < 20; k++) begin
            start = (k % 3 == 0);
            @(negedge clk);
            check("bp_stable", {out_valid, busy, out_class, out_value}, {1'b1, 1'b1, 4'd9, 16'd5});
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        check("bp_handshake_start_ignored", {out_valid, in_ready, busy}, 3'b000);
        @(negedge clk);
        check("bp_still_idle", busy, 0);

        // Extremes
        beats[0] = 16'hFFFF;
        for (int i = 1; i < 10; i++) beats[i] = 16'h0;
        pulse_start();
        send_beats(10, 1'b0);
        check_result("max_first", 4'd0, 16'hFFFF);
        handshake_out();
        for (int i = 0; i < 10; i++) beats[i] = 16'h0;
        pulse_start();
        send_beats(10, 1'b0);
        check_result("all_zero", 4'd9, 16'h0);
        handshake_out();

        // Reset mid-frame discards the partial frame
        beats[0] = 1000; beats[1] = 2000; beats[2] = 3000; beats[3] = 4000;
        pulse_start();
        send_beats(4, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_ctrl", {out_valid, in_ready, busy}, 3'b000);
        check("midreset_outs", {out_class, out_value}, 20'h0);
        beats[0] = 10; beats[1] = 20; beats[2] = 30; beats[3] = 40; beats[4] = 50;
        beats[5] = 60; beats[6] = 70; beats[7] = 80; beats[8] = 90; beats[9] = 15;
        pulse_start();
        send_beats(10, 1'b0);
        check_result("post_reset", 4'd8, 16'd90);
        handshake_out();

        // 16 classes: maximum at index 15, tied with index 7
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid16 = 1'b1;
            in_data16  = (i == 7 || i == 15) ? 16'd200 : 16'(i * 3);
            @(negedge clk);
        end
        in_valid16 = 1'b0;
        check("n16_valid", {out_valid16, in_ready16, busy16}, 3'b101);
        check("n16_class", out_class16, 15);
        check("n16_value", out_value16, 200);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("n16_idle", busy16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
